// File: rtl/seven_seg_reader.sv
// Recovers the hex nibble shown on an active-low 7-segment bus once the pattern has held
// steady, and hands it off through a one-entry valid/ready buffer.
module seven_seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_n,
    input  logic       out_ready,
    output logic [3:0] out_value,
    output logic       out_valid,
    output logic       err_invalid,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [6:0] BLANK = 7'h7F;

    logic [6:0]    seg_q, seg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [3:0]    value_q, value_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;

    logic          evt;
    logic          legal;
    logic [3:0]    nib;

    // Reverse glyph table: seg_n codes (bit0 = a) back to the nibble they display.
    always_comb begin
        {legal, nib} = 5'h00;
        case (seg_q)
            7'h40: {legal, nib} = 5'h10;
            7'h79: {legal, nib} = 5'h11;
            7'h24: {legal, nib} = 5'h12;
            7'h30: {legal, nib} = 5'h13;
            7'h19: {legal, nib} = 5'h14;
            7'h12: {legal, nib} = 5'h15;
            7'h02: {legal, nib} = 5'h16;
            7'h78: {legal, nib} = 5'h17;
            7'h00: {legal, nib} = 5'h18;
            7'h10: {legal, nib} = 5'h19;
            7'h08: {legal, nib} = 5'h1A;
            7'h03: {legal, nib} = 5'h1B;
            7'h46: {legal, nib} = 5'h1C;
            7'h21: {legal, nib} = 5'h1D;
            7'h06: {legal, nib} = 5'h1E;
            7'h0E: {legal, nib} = 5'h1F;
            default: {legal, nib} = 5'h00;
        endcase
    end

    assign evt = (cnt_q == CNT_MAX) && armed_q;

    always_comb begin
        seg_d   = seg_n;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        value_d = value_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        err_d   = evt && !legal && (seg_q != BLANK);

        // A pattern change re-arms, and wins over the disarm of an event in the same cycle.
        if (evt) armed_d = 1'b0;
        if (seg_n != seg_q) begin
            cnt_d   = CW'(1);
            armed_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (evt && legal) begin
            if (!valid_q || out_ready) begin
                value_d = nib;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= BLANK;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            value_q <= 4'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_value   = value_q;
    assign out_valid   = valid_q;
    assign err_invalid = err_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Randomized and directed bench for seven_seg_reader against a run-length reference model.
module tb_seven_seg_reader;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_n;
    logic       out_ready;
    logic [3:0] out_value;
    logic       out_valid;
    logic       err_invalid;
    logic       overrun;

    always #5 clk = ~clk;

    seven_seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .out_ready(out_ready),
        .out_value(out_value), .out_valid(out_valid),
        .err_invalid(err_invalid), .overrun(overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Glyphs written as lit-segment bitmasks (a = bit0), inverted for the active-low bus.
    logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] glyph(int d);
        return ~lit[d];
    endfunction

    // Model state: last sampled pattern and how many consecutive edges it has been sampled.
    logic [6:0] m_seg;
    int         m_run;
    logic [3:0] m_val;
    logic       m_vld, m_err, m_ovr;

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit fire, is_legal;
        int nibble;
        if (rst) begin
            m_seg = 7'h7F; m_run = 0; m_val = 0; m_vld = 0; m_err = 0; m_ovr = 0;
            return;
        end
        fire = (m_run == S);
        is_legal = 0;
        nibble = 0;
        for (int d = 0; d < 16; d++)
            if (glyph(d) == m_seg) begin is_legal = 1; nibble = d; end
        m_err = fire && !is_legal && (m_seg != 7'h7F);
        if (fire && is_legal) begin
            if (!m_vld || out_ready) begin m_val = 4'(nibble); m_vld = 1; end
            else m_ovr = 1;
        end else if (m_vld && out_ready) begin
            m_vld = 0;
        end
        if (seg_n != m_seg) m_run = 1;
        else if (m_run < 1000) m_run++;
        m_seg = seg_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", 8'(out_valid), 8'(m_vld));
        if (m_vld) chk("out_value", 8'(out_value), 8'(m_val));
        chk("err_invalid", 8'(err_invalid), 8'(m_err));
        chk("overrun", 8'(overrun), 8'(m_ovr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg_n = 7'h7F;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic hold(logic [6:0] p, int n);
        seg_n = p;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int errs, cyc;
        logic [3:0] seen[$];

        m_seg = 7'h7F; m_run = 0; m_val = 0; m_vld = 0; m_err = 0; m_ovr = 0;
        do_reset();
        chk("rst_valid", 8'(out_valid), 8'h0);
        chk("rst_ovr", 8'(overrun), 8'h0);
        chk("rst_err", 8'(err_invalid), 8'h0);

        // "3" held with no consumer: appears after the fifth edge of the hold.
        hold(7'h30, 4);
        chk("three_early", 8'(out_valid), 8'h0);
        hold(7'h30, 1);
        chk("three_valid", 8'(out_valid), 8'h1);
        chk("three_value", 8'(out_value), 8'h3);
        hold(7'h30, 12);
        chk("three_hold", 8'(out_valid), 8'h1);
        chk("three_ovr", 8'(overrun), 8'h0);

        // Short hold produces nothing; a full hold does.
        do_reset();
        hold(7'h08, 3);
        hold(7'h7F, 4);
        chk("short_valid", 8'(out_valid), 8'h0);
        hold(7'h08, 5);
        chk("a_valid", 8'(out_valid), 8'h1);
        chk("a_value", 8'(out_value), 8'hA);

        // Invalid pattern: one err pulse, buffer untouched, then quiet blank.
        do_reset();
        seg_n = 7'h7E;
        errs = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (err_invalid) errs++; end
        seg_n = 7'h7F;
        for (int i = 0; i < 8; i++) begin tick(); if (err_invalid) errs++; end
        chk("err_pulses", 8'(errs), 8'h1);
        chk("err_no_valid", 8'(out_valid), 8'h0);

        // Sweep all glyphs with the consumer always ready.
        do_reset();
        out_ready = 1'b1;
        seen.delete();
        for (int d = 0; d <= 16; d++) begin
            seg_n = (d < 16) ? glyph(d) : 7'h7F;
            for (int i = 0; i < 4; i++) begin tick(); if (out_valid) seen.push_back(out_value); end
        end
        chk("sweep_count", 8'(seen.size()), 8'd16);
        for (int d = 0; d < 16 && d < seen.size(); d++) chk("sweep_value", 8'(seen[d]), 8'(d));
        chk("sweep_ovr", 8'(overrun), 8'h0);

        // Overrun: second value dropped while the first waits.
        do_reset();
        hold(7'h79, 4);
        hold(7'h24, 4);
        hold(7'h7F, 2);
        chk("ovr_value", 8'(out_value), 8'h1);
        chk("ovr_flag", 8'(overrun), 8'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovr_consumed", 8'(out_valid), 8'h0);
        hold(7'h7F, 3);
        chk("ovr_sticky", 8'(overrun), 8'h1);

        // Reset in the middle of a hold.
        do_reset();
        hold(7'h00, 2);
        rst = 1'b1;
        tick();
        chk("midrst_valid0", 8'(out_valid), 8'h0);
        tick();
        chk("midrst_valid1", 8'(out_valid), 8'h0);
        rst = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 12) begin tick(); cyc++; end
        chk("midrst_latency", 8'(cyc), 8'd5);
        chk("midrst_value", 8'(out_value), 8'h8);

        // Random patterns, hold lengths, consumer behaviour and occasional resets.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            int sel, len;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) seg_n = glyph(int'($urandom_range(0, 15)));
            else if (sel < 8) seg_n = 7'h7F;
            else seg_n = 7'($urandom);
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                rst = ($urandom_range(0, 60) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
